// File: rtl/bsg_link_upstream_arbiter.sv
// bsg_link_upstream_arbiter
//
// Packet-locked round-robin arbiter that shares one DDR link upstream
// core-side ready/valid input among num_req_p requesters. Once a requester
// wins, it keeps the grant until its last beat is accepted, so multi-flit
// packets are never interleaved. The merged stream passes through a 2-entry
// buffer, so the link-facing outputs are registered. The source requester ID
// travels with every beat.
//
// Ports:
//   clk_i, reset_i     core clock, synchronous active-high reset
//   en_mask_i          per-requester enable for new grants
//   valid_i/data_i/last_i/ready_o  per-requester ready/valid inputs
//                      (requester i uses data_i[i*width_p +: width_p])
//   valid_o/data_o/last_o/id_o/ready_i  merged output stream to the link
//   locked_o, owner_o  packet lock status and current lock owner
module bsg_link_upstream_arbiter #(
   parameter int num_req_p = 4,
   parameter int width_p   = 8,
   localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [num_req_p-1:0]           en_mask_i,
   input  logic [num_req_p-1:0]           valid_i,
   input  logic [num_req_p*width_p-1:0]   data_i,
   input  logic [num_req_p-1:0]           last_i,
   output logic [num_req_p-1:0]           ready_o,
   output logic                           valid_o,
   output logic [width_p-1:0]             data_o,
   output logic                           last_o,
   output logic [lg_num_req_lp-1:0]       id_o,
   input  logic                           ready_i,
   output logic                           locked_o,
   output logic [lg_num_req_lp-1:0]       owner_o
);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e                     state_r;
   logic [lg_num_req_lp-1:0]   ptr_r;
   logic [lg_num_req_lp-1:0]   owner_r;
   logic [1:0]                 count_r;

   logic [width_p-1:0]         head_data_r, tail_data_r;
   logic                       head_last_r, tail_last_r;
   logic [lg_num_req_lp-1:0]   head_id_r, tail_id_r;

   logic [num_req_p-1:0]       cand;
   logic [lg_num_req_lp:0]     scan_sum;
   logic [lg_num_req_lp-1:0]   winner;
   logic                       found;
   logic [lg_num_req_lp-1:0]   sel;
   logic                       space;
   logic                       enq, deq;
   logic [width_p-1:0]         enq_data;
   logic                       enq_last;

   function automatic logic [lg_num_req_lp-1:0] wrap_inc(input logic [lg_num_req_lp-1:0] v);
      return (v == lg_num_req_lp'(num_req_p - 1)) ? '0 : v + lg_num_req_lp'(1);
   endfunction

   assign cand  = valid_i & en_mask_i;
   assign space = (count_r != 2'd2);

   // First candidate at or after the pointer, wrapping modulo num_req_p.
   always_comb begin
      winner   = '0;
      found    = 1'b0;
      scan_sum = '0;
      for (int k = 0; k < num_req_p; k++) begin
         scan_sum = {1'b0, ptr_r} + (lg_num_req_lp+1)'(k);
         if (scan_sum >= (lg_num_req_lp+1)'(num_req_p))
            scan_sum = scan_sum - (lg_num_req_lp+1)'(num_req_p);
         if (!found && cand[scan_sum[lg_num_req_lp-1:0]]) begin
            found  = 1'b1;
            winner = scan_sum[lg_num_req_lp-1:0];
         end
      end
   end

   // While locked the owner keeps the grant regardless of its enable bit.
   assign sel = (state_r == LOCKED) ? owner_r : winner;

   // ready_o never looks at ready_i: space is judged from the count at the
   // start of the cycle, so a full buffer blocks enqueue even when draining.
   always_comb begin
      ready_o = '0;
      if (!reset_i && ((state_r == LOCKED) || found))
         ready_o[sel] = space;
   end

   assign enq      = |(valid_i & ready_o);
   assign enq_data = data_i[sel*width_p +: width_p];
   assign enq_last = last_i[sel];
   assign deq      = (count_r != 2'd0) & ready_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         ptr_r   <= '0;
         owner_r <= '0;
         count_r <= 2'd0;
      end else begin
         count_r <= count_r + 2'(enq) - 2'(deq);
         if (enq) begin
            if (enq_last) begin
               state_r <= IDLE;
               ptr_r   <= wrap_inc(sel);
               owner_r <= '0;
            end else if (state_r == IDLE) begin
               state_r <= LOCKED;
               owner_r <= winner;
            end
         end
      end
   end

   // Buffer storage: the head register always drives the outputs.
   always_ff @(posedge clk_i) begin
      if (enq && ((count_r == 2'd0) || ((count_r == 2'd1) && deq))) begin
         head_data_r <= enq_data;
         head_last_r <= enq_last;
         head_id_r   <= sel;
      end else if (deq && (count_r == 2'd2)) begin
         head_data_r <= tail_data_r;
         head_last_r <= tail_last_r;
         head_id_r   <= tail_id_r;
      end
      if (enq && (count_r == 2'd1) && !deq) begin
         tail_data_r <= enq_data;
         tail_last_r <= enq_last;
         tail_id_r   <= sel;
      end
   end

   assign valid_o  = (count_r != 2'd0);
   assign data_o   = head_data_r;
   assign last_o   = head_last_r;
   assign id_o     = head_id_r;
   assign locked_o = (state_r == LOCKED);
   assign owner_o  = (state_r == LOCKED) ? owner_r : '0;

`ifndef SYNTHESIS
   a_num_req: assert property (@(posedge clk_i) num_req_p >= 1);

   for (genvar i = 0; i < num_req_p; i++) begin : g_hold
      a_valid_hold: assert property (@(posedge clk_i) disable iff (reset_i)
         (valid_i[i] && !ready_o[i]) |=> valid_i[i]);
   end
`endif

endmodule

// File: tb/tb_bsg_link_upstream_arbiter.sv
module tb_bsg_link_upstream_arbiter;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic [N-1:0]   en_mask_i;
   logic [N-1:0]   valid_i;
   logic [N*W-1:0] data_i;
   logic [N-1:0]   last_i;
   logic [N-1:0]   ready_o;
   logic           valid_o;
   logic [W-1:0]   data_o;
   logic           last_o;
   logic [1:0]     id_o;
   logic           ready_i;
   logic           locked_o;
   logic [1:0]     owner_o;

   int n_checks = 0;
   int n_errors = 0;

   bsg_link_upstream_arbiter #(.num_req_p(N), .width_p(W)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_mask_i(en_mask_i),
      .valid_i(valid_i), .data_i(data_i), .last_i(last_i), .ready_o(ready_o),
      .valid_o(valid_o), .data_o(data_o), .last_o(last_o), .id_o(id_o),
      .ready_i(ready_i), .locked_o(locked_o), .owner_o(owner_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       rst;
      logic [3:0] en, vld, lst;
      logic [3:0] e_rdy;
      logic       e_vld;
      logic [1:0] e_id;
      logic       e_last, e_lock;
      logic [1:0] e_own;
   } vec_t;

   typedef struct {
      int         id;
      logic       last;
      logic [W-1:0] data;
   } beat_t;

   vec_t tbl_main[27];
   vec_t tbl_rst[8];

   // stall sequence: req0 data index (-1 = idle), ready_i, expected ready_o[0], expected output index
   int s_dix[10] = '{0, 1, 2, 2, 2, 2, 2, 3, -1, -1};
   int s_rdy[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
   int s_er [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
   int s_out[10] = '{-1, 0, 0, 0, 0, 0, 1, 2, 3, -1};

   function automatic vec_t mk(logic rst, logic [3:0] en, logic [3:0] vld, logic [3:0] lst,
                               logic [3:0] er, logic ev, int eid, logic el, logic elk, int eo);
      vec_t v;
      v.rst = rst; v.en = en; v.vld = vld; v.lst = lst; v.e_rdy = er; v.e_vld = ev;
      v.e_id = 2'(eid); v.e_last = el; v.e_lock = elk; v.e_own = 2'(eo);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_const_data();
      for (int i = 0; i < N; i++) data_i[i*W +: W] = 16'hA000 + 16'(i);
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      reset_i = v.rst; en_mask_i = v.en; valid_i = v.vld; last_i = v.lst; ready_i = 1'b1;
      #1;
      chk({tag, ".ready_o"}, 32'(ready_o), 32'(v.e_rdy));
      chk({tag, ".valid_o"}, 32'(valid_o), 32'(v.e_vld));
      if (v.e_vld) begin
         chk({tag, ".id_o"}, 32'(id_o), 32'(v.e_id));
         chk({tag, ".last_o"}, 32'(last_o), 32'(v.e_last));
         chk({tag, ".data_o"}, 32'(data_o), 32'(16'hA000 | 16'(v.e_id)));
      end
      chk({tag, ".locked_o"}, 32'(locked_o), 32'(v.e_lock));
      chk({tag, ".owner_o"}, 32'(owner_o), 32'(v.e_own));
      cyc();
   endtask

   task automatic do_reset();
      reset_i = 1'b1; valid_i = '0; last_i = '0; en_mask_i = '1; ready_i = 1'b1;
      cyc();
      cyc();
   endtask

   // Random traffic against a queue-based reference model.
   task automatic run_random(input int cycles);
      beat_t        q[$];
      int           m_owner, m_ptr, acc, j, out_cur;
      logic [N-1:0] r_vld, r_lst, r_en, e_rdy;
      logic [W-1:0] r_dat[N];
      int           seq_in[N], seq_out[N], wait_pk[N];
      logic         space, found, rdy;
      beat_t        b;

      m_owner = -1; m_ptr = 0; out_cur = -1;
      r_vld = '0; r_lst = '0; r_en = '1;
      for (int i = 0; i < N; i++) begin
         seq_in[i] = 0; seq_out[i] = 0; wait_pk[i] = 0; r_dat[i] = '0;
      end

      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!r_vld[i] && ($urandom_range(1, 0) == 1)) begin
               r_vld[i] = 1'b1;
               r_lst[i] = ($urandom_range(2, 0) == 0);
               r_dat[i] = {4'(i), 12'(seq_in[i])};
               seq_in[i]++;
            end
         end
         if ($urandom_range(63, 0) == 0) r_en = 4'($urandom);
         rdy = ($urandom_range(3, 0) != 0);
         reset_i = 1'b0; en_mask_i = r_en; valid_i = r_vld; last_i = r_lst; ready_i = rdy;
         for (int i = 0; i < N; i++) data_i[i*W +: W] = r_dat[i];
         #1;

         space = (q.size() < 2);
         e_rdy = '0;
         found = 1'b0;
         if (m_owner >= 0) e_rdy[m_owner] = space;
         else begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (!found && r_vld[j] && r_en[j]) begin
                  found = 1'b1;
                  e_rdy[j] = space;
               end
            end
         end

         chk("rnd.ready_o", 32'(ready_o), 32'(e_rdy));
         chk("rnd.valid_o", 32'(valid_o), 32'(q.size() != 0));
         if (valid_o && q.size() != 0) begin
            chk("rnd.data_o", 32'(data_o), 32'(q[0].data));
            chk("rnd.id_o", 32'(id_o), 32'(q[0].id));
            chk("rnd.last_o", 32'(last_o), 32'(q[0].last));
         end
         chk("rnd.locked_o", 32'(locked_o), 32'(m_owner >= 0));
         chk("rnd.owner_o", 32'(owner_o), 32'((m_owner >= 0) ? m_owner : 0));

         // Output stream: packets contiguous, per-requester sequence in order.
         if (valid_o && ready_i) begin
            if (out_cur >= 0) chk("rnd.contiguous", 32'(id_o), 32'(out_cur));
            chk("rnd.order", 32'(data_o[11:0]), 32'(12'(seq_out[id_o])));
            seq_out[id_o]++;
            out_cur = last_o ? -1 : int'(id_o);
         end

         if (q.size() != 0 && rdy) void'(q.pop_front());
         acc = -1;
         for (int i = 0; i < N; i++) if (r_vld[i] && e_rdy[i]) acc = i;
         if (acc >= 0) begin
            b.id = acc; b.last = r_lst[acc]; b.data = r_dat[acc];
            q.push_back(b);
            r_vld[acc] = 1'b0;
            wait_pk[acc] = 0;
            if (b.last) begin
               for (int i = 0; i < N; i++) begin
                  if (i != acc && r_vld[i] && r_en[i]) begin
                     wait_pk[i]++;
                     if (wait_pk[i] >= N) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rnd.fairness: req%0d waited %0d packets, limit %0d", i, wait_pk[i], N - 1);
                     end
                  end
               end
               m_owner = -1;
               m_ptr = (acc + 1) % N;
            end else begin
               m_owner = acc;
            end
         end
         for (int i = 0; i < N; i++) if (!(r_vld[i] && r_en[i])) wait_pk[i] = 0;
         cyc();
      end
   endtask

   initial begin
      reset_i = 1'b1; en_mask_i = '1; valid_i = '0; last_i = '0; ready_i = 1'b1;
      set_const_data();

      tbl_main[0]  = mk(0, 4'hF, 4'hF, 4'hF, 4'b0001, 0, 0, 0, 0, 0);
      tbl_main[1]  = mk(0, 4'hF, 4'hF, 4'hF, 4'b0010, 1, 0, 1, 0, 0);
      tbl_main[2]  = mk(0, 4'hF, 4'hF, 4'hF, 4'b0100, 1, 1, 1, 0, 0);
      tbl_main[3]  = mk(0, 4'hF, 4'hF, 4'hF, 4'b1000, 1, 2, 1, 0, 0);
      tbl_main[4]  = mk(0, 4'hF, 4'hF, 4'hF, 4'b0001, 1, 3, 1, 0, 0);
      tbl_main[5]  = mk(0, 4'hF, 4'hE, 4'hF, 4'b0010, 1, 0, 1, 0, 0);
      tbl_main[6]  = mk(0, 4'hF, 4'hC, 4'hF, 4'b0100, 1, 1, 1, 0, 0);
      tbl_main[7]  = mk(0, 4'hF, 4'h8, 4'hF, 4'b1000, 1, 2, 1, 0, 0);
      tbl_main[8]  = mk(0, 4'hF, 4'h2, 4'h0, 4'b0010, 1, 3, 1, 0, 0);
      tbl_main[9]  = mk(0, 4'hF, 4'h7, 4'h5, 4'b0010, 1, 1, 0, 1, 1);
      tbl_main[10] = mk(0, 4'hF, 4'h7, 4'h7, 4'b0010, 1, 1, 0, 1, 1);
      tbl_main[11] = mk(0, 4'hF, 4'h5, 4'h5, 4'b0100, 1, 1, 1, 0, 0);
      tbl_main[12] = mk(0, 4'hF, 4'h1, 4'h1, 4'b0001, 1, 2, 1, 0, 0);
      tbl_main[13] = mk(0, 4'hF, 4'h0, 4'h0, 4'b0000, 1, 0, 1, 0, 0);
      tbl_main[14] = mk(0, 4'hF, 4'h0, 4'h0, 4'b0000, 0, 0, 0, 0, 0);
      tbl_main[15] = mk(0, 4'hA, 4'hF, 4'hF, 4'b0010, 0, 0, 0, 0, 0);
      tbl_main[16] = mk(0, 4'hA, 4'hF, 4'hF, 4'b1000, 1, 1, 1, 0, 0);
      tbl_main[17] = mk(0, 4'hA, 4'hF, 4'hF, 4'b0010, 1, 3, 1, 0, 0);
      tbl_main[18] = mk(0, 4'hA, 4'hF, 4'hF, 4'b1000, 1, 1, 1, 0, 0);
      tbl_main[19] = mk(0, 4'hA, 4'hF, 4'hD, 4'b0010, 1, 3, 1, 0, 0);
      tbl_main[20] = mk(0, 4'h8, 4'hF, 4'hD, 4'b0010, 1, 1, 0, 1, 1);
      tbl_main[21] = mk(0, 4'h8, 4'hF, 4'hF, 4'b0010, 1, 1, 0, 1, 1);
      tbl_main[22] = mk(0, 4'h8, 4'hD, 4'hF, 4'b1000, 1, 1, 1, 0, 0);
      tbl_main[23] = mk(0, 4'hF, 4'h5, 4'hF, 4'b0001, 1, 3, 1, 0, 0);
      tbl_main[24] = mk(0, 4'hF, 4'h4, 4'hF, 4'b0100, 1, 0, 1, 0, 0);
      tbl_main[25] = mk(0, 4'hF, 4'h0, 4'hF, 4'b0000, 1, 2, 1, 0, 0);
      tbl_main[26] = mk(0, 4'hF, 4'h0, 4'hF, 4'b0000, 0, 0, 0, 0, 0);

      tbl_rst[0] = mk(0, 4'hF, 4'h1, 4'h0, 4'b0001, 0, 0, 0, 0, 0);
      tbl_rst[1] = mk(0, 4'hF, 4'h1, 4'h0, 4'b0001, 1, 0, 0, 1, 0);
      tbl_rst[2] = mk(1, 4'hF, 4'h0, 4'h0, 4'b0000, 1, 0, 0, 1, 0);
      tbl_rst[3] = mk(0, 4'hF, 4'h5, 4'h1, 4'b0001, 0, 0, 0, 0, 0);
      tbl_rst[4] = mk(0, 4'hF, 4'h4, 4'h0, 4'b0100, 1, 0, 1, 0, 0);
      tbl_rst[5] = mk(0, 4'hF, 4'h4, 4'h4, 4'b0100, 1, 2, 0, 1, 2);
      tbl_rst[6] = mk(0, 4'hF, 4'h0, 4'h0, 4'b0000, 1, 2, 1, 0, 0);
      tbl_rst[7] = mk(0, 4'hF, 4'h0, 4'h0, 4'b0000, 0, 0, 0, 0, 0);

      do_reset();
      chk("reset.valid_o", 32'(valid_o), 32'd0);
      chk("reset.locked_o", 32'(locked_o), 32'd0);
      chk("reset.owner_o", 32'(owner_o), 32'd0);
      chk("reset.ready_o", 32'(ready_o), 32'd0);

      for (int k = 0; k < 27; k++) apply_vec(tbl_main[k], $sformatf("main%0d", k));

      // Link stalls for 5 cycles while req0 streams single-beat packets.
      for (int k = 0; k < 10; k++) begin
         reset_i = 1'b0; en_mask_i = '1; last_i = 4'b0001;
         valid_i = (s_dix[k] >= 0) ? 4'b0001 : 4'b0000;
         data_i[0 +: W] = 16'h5000 + 16'((s_dix[k] >= 0) ? s_dix[k] : 0);
         ready_i = s_rdy[k][0];
         #1;
         chk($sformatf("stall%0d.ready_o", k), 32'(ready_o), 32'(s_er[k]));
         chk($sformatf("stall%0d.valid_o", k), 32'(valid_o), 32'(s_out[k] >= 0));
         if (s_out[k] >= 0) begin
            chk($sformatf("stall%0d.data_o", k), 32'(data_o), 32'(16'h5000 + 16'(s_out[k])));
            chk($sformatf("stall%0d.id_o", k), 32'(id_o), 32'd0);
         end
         cyc();
      end
      set_const_data();

      for (int k = 0; k < 8; k++) apply_vec(tbl_rst[k], $sformatf("rst%0d", k));

      do_reset();
      run_random(10000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
